// File: rtl/fica_pkg.sv
`default_nettype none
// ============================================================================
// fica_pkg : shared constants and FSM encoding for the matrix stream-out block
// Revision : 1.0
// ============================================================================
package fica_pkg;

    localparam int DW        = 26;   // signed Q12.13 element width
    localparam int FRAC_W    = 13;
    localparam int FRAME_LEN = 64;
    localparam int IDX_W     = 6;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mat_frame_buf.sv
`default_nettype none
// ============================================================================
// mat_frame_buf : frame capture buffer, read mux and element index counter
// Revision      : 1.0
// ============================================================================
module mat_frame_buf #(
    parameter int DW    = fica_pkg::DW,
    parameter int N_MAT = 4,
    parameter int N_EL  = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         capture,
    input  logic                         advance,
    input  logic [N_MAT*N_EL*DW-1:0]     frame_in,
    output logic [DW-1:0]                rd_data,
    output logic [fica_pkg::IDX_W-1:0]   idx,
    output logic                         idx_last
);
    import fica_pkg::*;

    localparam int FRAME = N_MAT * N_EL;

    logic [DW-1:0] frame_mem [FRAME];

    // Storage carries no reset: it is only ever read after a capture.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int k = 0; k < FRAME; k++) begin
                frame_mem[k] <= frame_in[k*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
        end else if (capture) begin
            idx <= '0;
        end else if (advance) begin
            idx <= idx + IDX_W'(1);
        end
    end

    assign rd_data  = frame_mem[idx];
    assign idx_last = (idx == IDX_W'(FRAME - 1));

endmodule
`default_nettype wire

// File: rtl/mat_stream_out.sv
`default_nettype none
// ============================================================================
// mat_stream_out : captures a 64-element matrix frame and streams it out
//                  element by element over a valid/ready handshake
// Revision       : 1.0
// ============================================================================
module mat_stream_out #(
    parameter int DW    = fica_pkg::DW,
    parameter int N_MAT = 4,
    parameter int N_EL  = 16
) (
    input  logic                         clk_ser,
    input  logic                         rst_n_ser,
    input  logic                         en_ser,
    input  logic [N_MAT*N_EL*DW-1:0]     mat_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DW-1:0]                out_data,
    output logic [5:0]                   out_idx,
    output logic                         out_last,
    output logic                         busy,
    output logic                         done,
    output logic                         ovf_err
);
    import fica_pkg::*;

    state_t             state;
    state_t             state_nxt;
    logic               capture;
    logic               transfer;
    logic               done_nxt;
    logic               ovf_nxt;
    logic [DW-1:0]      buf_data;
    logic [IDX_W-1:0]   buf_idx;
    logic               buf_last;

    mat_frame_buf #(
        .DW    (DW),
        .N_MAT (N_MAT),
        .N_EL  (N_EL)
    ) u_frame_buf (
        .clk      (clk_ser),
        .rst_n    (rst_n_ser),
        .capture  (capture),
        .advance  (transfer),
        .frame_in (mat_in),
        .rd_data  (buf_data),
        .idx      (buf_idx),
        .idx_last (buf_last)
    );

    always_ff @(posedge clk_ser or negedge rst_n_ser) begin
        if (!rst_n_ser) begin
            state   <= ST_IDLE;
            done    <= 1'b0;
            ovf_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            done    <= done_nxt;
            ovf_err <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        capture   = 1'b0;
        transfer  = 1'b0;
        done_nxt  = 1'b0;
        ovf_nxt   = ovf_err;
        out_valid = 1'b0;
        busy      = 1'b0;
        out_data  = '0;
        out_idx   = '0;
        out_last  = 1'b0;

        case (state)
            ST_IDLE: begin
                if (en_ser) begin
                    capture   = 1'b1;
                    state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                busy      = 1'b1;
                out_data  = buf_data;
                out_idx   = buf_idx;
                out_last  = buf_last;
                transfer  = out_ready;
                // A capture request is only honoured on the final transfer,
                // which lets a new frame follow with no idle cycle.
                if (transfer && buf_last) begin
                    done_nxt = 1'b1;
                    if (en_ser) begin
                        capture = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else if (en_ser) begin
                    ovf_nxt = 1'b1;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: doc/mat_stream_out.md
MAT_STREAM_OUT -- requirements
Module: mat_stream_out

Interface
REQ-001 SHALL have parameter DW, default 26, meaning element width in bits, signed Q12.13 fixed point.
REQ-002 SHALL have parameter N_MAT, default 4, meaning the number of 4x4 matrices per frame.
REQ-003 SHALL have parameter N_EL, default 16, meaning the number of elements per matrix.
REQ-004 SHALL have port clk_ser, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n_ser, input, 1 bit: asynchronous active-low reset.
REQ-006 SHALL have port en_ser, input, 1 bit: capture request; a frame is sampled from mat_in on the same edge.
REQ-007 SHALL have port mat_in, input, N_MAT*N_EL*DW bits: packed frame of four matrix-product results.
  - Element k occupies bits [k*DW +: DW].
  - k = m*16 + (r-1)*4 + (c-1), where m is 0..3 (matrix), r is the row and c is the column.
REQ-008 SHALL have port out_valid, output, 1 bit: out_data holds a valid element.
REQ-009 SHALL have port out_ready, input, 1 bit: the downstream consumer accepts the element.
REQ-010 SHALL have port out_data, output, DW bits: current element, signed.
REQ-011 SHALL have port out_idx, output, 6 bits: frame index k of the current element.
REQ-012 SHALL have port out_last, output, 1 bit: high while k = 63.
REQ-013 SHALL have port busy, output, 1 bit: a frame is being streamed.
REQ-014 SHALL have port done, output, 1 bit: one-cycle pulse when a frame completes.
REQ-015 SHALL have port ovf_err, output, 1 bit: sticky flag set when a capture request is dropped.

Function
REQ-016 SHALL implement two states, IDLE and SEND; reset enters IDLE.
REQ-017 In IDLE, en_ser=1 SHALL latch all 64 elements into an internal buffer, clear the index to 0 and enter SEND on the same edge.
REQ-018 In SEND, out_valid SHALL be 1; out_data SHALL be buffer[idx] and out_idx SHALL be idx.
REQ-019 A transfer SHALL occur exactly when out_valid and out_ready are both 1 at a rising edge; idx then increments by 1.
REQ-020 While out_valid=1 and out_ready=0, out_data, out_idx and out_last SHALL hold stable; out_valid SHALL NOT drop until the transfer occurs.
REQ-021 Latency SHALL be one cycle: en_ser sampled at edge t gives out_valid=1 with element 0 after edge t.
REQ-022 A transfer at idx=63 SHALL return the block to IDLE and pulse done=1 for exactly the following cycle.
REQ-023 en_ser=1 in the same cycle as the idx=63 transfer SHALL be accepted (back-to-back).
  - The new frame is captured, idx resets to 0 and the block stays in SEND with no idle cycle.
  - done still pulses.
REQ-024 en_ser=1 in SEND at any other time SHALL be ignored, leaving buffer and idx unchanged, and SHALL set ovf_err=1.
REQ-025 ovf_err SHALL remain set until reset.
REQ-026 out_data SHALL be a bit-exact copy of the captured element; no rounding or saturation.
REQ-027 mat_in SHALL be sampled only on a capture edge; later changes to mat_in SHALL NOT affect the frame being streamed.
REQ-028 busy SHALL equal (state == SEND).
REQ-029 In IDLE, out_valid, out_last and busy SHALL be 0, and out_data and out_idx SHALL be 0.

Reset
REQ-030 Asserting rst_n_ser=0 SHALL immediately force IDLE, with idx=0 and out_valid, out_data, out_idx, out_last, busy, done and ovf_err all 0.
REQ-031 Reset during SEND SHALL abort the frame: no done pulse, and no further transfers until a new en_ser.
REQ-032 The buffer contents need not be reset.
REQ-033 Deassertion of rst_n_ser is assumed synchronous to clk_ser at the system level.

Structure
REQ-034 DW, the fraction width (13), the frame length (64), the state encoding and the index width SHALL reside in the shared package fica_pkg.
REQ-035 The frame buffer plus index counter SHALL be one sub-module, mat_frame_buf (capture, read mux, idx counter).
REQ-036 The FSM and handshake logic SHALL reside in mat_stream_out.

Verification
REQ-037 Basic frame: load element k = k*8192 (k.0 in Q13), pulse en_ser, hold out_ready=1.
  - Required: 64 consecutive transfers with out_data = k*8192 and out_idx = k.
  - Required: out_last only at k = 63, and done pulsed one cycle later.
REQ-038 Backpressure: out_ready=0 for 5 cycles at k = 10.
  - Required: out_data = 81920 and out_idx = 10 held stable with out_valid=1; then k = 11 follows after ready is reasserted.
REQ-039 Back-to-back: en_ser with a frame of all -8192 asserted during the k = 63 transfer of the previous frame.
  - Required: next cycle out_idx=0 and out_data=-8192, busy stays 1, and done pulses.
REQ-040 Overrun: en_ser pulsed at k = 20.
  - Required: ovf_err=1 until reset, and the stream continues unchanged through k = 63 with the original data.
REQ-041 Reset abort: assert rst_n_ser low at k = 30.
  - Required: all outputs 0 asynchronously, no done pulse, and out_valid stays 0 until the next en_ser.
REQ-042 Sign and width: element values 33554431 and -33554432 SHALL be reproduced bit-exactly on out_data.
